sum_nb_chunked: RTL
===================

// Module: sum_nb_chunked
// PURPOSE
//   Parametrised multi-cycle adder/subtractor and next generation of the Sum4b ripple adder.
//   Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, carrying between chunks
//   in a register, so wide adds reuse one narrow adder. Start/Busy/Done handshake.
//   Outputs Sum, Cout and signed overflow. Sits between operand registers and the ALU result mux.
// PARAMETERS
//   WIDTH  16  operand/result width in bits (>=1)
//   CHUNK   4  bits added per cycle; must divide WIDTH, else elaboration $error
// PORTS
//   clk    in   1      clock; all state updates on rising edge
//   rst    in   1      synchronous, active-high reset
//   Start  in   1      request; sampled only in IDLE or DONE state
//   Sub    in   1      0: A+B+Ci   1: A-B (B inverted, carry-in forced 1, Ci ignored)
//   Ci     in   1      carry-in for add mode
//   A      in   WIDTH  operand A, captured on accepted Start
//   B      in   WIDTH  operand B, captured on accepted Start
//   Busy   out  1      high while chunks are being processed
//   Done   out  1      one-cycle pulse: Sum/Cout/Ovf valid
//   Sum    out  WIDTH  result, held until next completion
//   Cout   out  1      carry out of MSB (sub: 1 = no borrow)
//   Ovf    out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   N = WIDTH/CHUNK. Reset: state IDLE, chunk count 0, carry reg 0; Busy, Done, Sum, Cout, Ovf all 0.
//   FSM states: IDLE, RUN, DONE.
//   - IDLE -> RUN when Start=1 at edge E0.
//     On accept: latch A, (Sub ? ~B : B), carry reg = (Sub ? 1 : Ci), chunk count = 0.
//   - RUN, edges E1..EN: chunk i = bits [i*CHUNK +: CHUNK] adds with the carry reg.
//     Partial sum is stored internally; the carry reg is updated; count increments.
//   - At EN (last chunk): Sum, Cout, Ovf register; state -> DONE.
//   - DONE lasts one cycle (Done=1, Busy=0).
//     Start=1 at the next edge -> RUN (back-to-back accept). Otherwise -> IDLE.
//   - Busy=1 exactly in RUN (N cycles). Done rises N edges after the accepting edge E0.
//   - Start in RUN is ignored, not queued. A/B/Sub/Ci changes during RUN have no effect.
//   - Sum/Cout/Ovf change only at completion edges; partial results are never visible.
//   - N=1 (CHUNK=WIDTH): one RUN cycle; Done is visible one edge after E0.
//   - Unsigned wrap: result modulo 2^WIDTH; Cout carries the dropped bit.
//   - Reset mid-RUN: operation aborted, no Done pulse, outputs return to reset values.
//   - Reset has priority over Start on the same edge.
// TESTING (WIDTH=16, CHUNK=4 unless noted)
//   1. A=0x00FF B=0x0001 Ci=0 Sub=0 Start pulse -> Busy 4 cycles.
//      Done at E4 with Sum=0x0100, Cout=0, Ovf=0.
//   2. A=0xFFFF B=0x0001 add -> Sum=0x0000 Cout=1 Ovf=0.
//      A=0x7FFF B=0x0001 -> Sum=0x8000 Cout=0 Ovf=1.
//   3. Sub=1, A=0x0005 B=0x0007, Ci=1 (ignored) -> Sum=0xFFFE Cout=0 Ovf=0.
//      A=0x8000 B=0x0001 -> Sum=0x7FFF Cout=1 Ovf=1.
//   4. Start held high through RUN with changing A/B -> only the first operands are used.
//      In DONE cycle, Start with A=1 B=2 -> next Done 4 edges later, Sum=0x0003.
//   5. rst at E2 of a run -> Busy=0, Done never pulses, Sum/Cout/Ovf=0.
//      New Start afterwards completes normally.
//   6. Sweep WIDTH=4 CHUNK=1, and WIDTH=8 CHUNK=8 (N=1).
//      Exhaustive A, B, Ci, Sub vs. reference model; Done latency N each time.

Source files
------------

// File: rtl/sum_nb_chunked.sv
// sum_nb_chunked: multi-cycle adder/subtractor that pushes a WIDTH-bit add
// through one CHUNK-bit adder, one chunk per clock, with the inter-chunk
// carry held in a register. Start/Busy/Done handshake; Sum/Cout/Ovf are
// registered and only change when an operation completes.
module sum_nb_chunked #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             Sub,
    input  logic             Ci,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    // Refuse to build a configuration where the chunks do not tile the word
    if ((WIDTH < 1) || (CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("sum_nb_chunked: CHUNK (%0d) must divide WIDTH (%0d)", CHUNK, WIDTH);
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] part_sum;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             msb_carry_in;
    logic [WIDTH-1:0] next_part;
    logic             last_chunk;
    int               idx;

    // The single narrow adder: select the current chunk, add it with the
    // carry register, and merge the result into the partial sum
    always_comb begin
        idx          = int'(cnt) * CHUNK;
        a_chunk      = CHUNK'(a_reg >> idx);
        b_chunk      = CHUNK'(b_reg >> idx);
        chunk_sum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
        msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
        next_part    = (part_sum & ~(CHUNK_MASK << idx))
                     | (WIDTH'(chunk_sum[CHUNK-1:0]) << idx);
        last_chunk   = (cnt == CW'(N - 1));
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            part_sum <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Sum      <= '0;
            Cout     <= 1'b0;
            Ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        a_reg <= A;
                        b_reg <= Sub ? ~B : B;
                        carry <= Sub ? 1'b1 : Ci;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    part_sum <= next_part;
                    carry    <= chunk_sum[CHUNK];
                    cnt      <= cnt + CW'(1);
                    if (last_chunk) begin
                        Sum   <= next_part;
                        Cout  <= chunk_sum[CHUNK];
                        Ovf   <= msb_carry_in ^ chunk_sum[CHUNK];
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
